// File: rtl/platform_pkg.sv
// Shared types and constants for the platform manager: FSM states, screen size,
// LFSR seed/taps and the power-on platform layout.
package platform_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        LAND   = 2'd2,
        SCROLL = 2'd3
    } state_e;

    localparam int H_MAX = 640;
    localparam int V_MAX = 480;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift mask for taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int RST_Y0     = 470;
    localparam int RST_Y_STEP = 60;
    localparam int RST_X0     = 300;
    localparam int RST_X_STEP = 80;
    localparam int RST_X_MOD  = 600;

    function automatic logic [9:0] reset_y(input int i);
        int y;
        y = (RST_Y0 - RST_Y_STEP * i) % V_MAX;
        if (y < 0) y = y + V_MAX;
        return 10'(y);
    endfunction

    function automatic logic [9:0] reset_x(input int i);
        if (i == 0) return 10'(RST_X0);
        return 10'((i * RST_X_STEP) % RST_X_MOD);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the respawn X source.
module lfsr16
    import platform_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge Clk) begin
        if (Reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/platform_manager.sv
// Platform tracker: per-frame landing check, world scroll with respawn, and pixel hit test.
// Optional running score output enabled by defining PLATFORM_SCORE_EN.
//   state  | meaning
//   IDLE   | waiting for a frame strobe edge
//   CHECK  | testing one platform per cycle for a landing hit
//   LAND   | publishing land/land_y, deciding whether to scroll
//   SCROLL | shifting one platform per cycle down by dy, respawning off-screen ones
module platform_manager
    import platform_pkg::*;
#(
    parameter int NUM_PLAT    = 8,
    parameter int PLAT_W      = 40,
    parameter int PLAT_H      = 4,
    parameter int SCROLL_LINE = 160
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    input  logic        ball_falling,
    output logic        land,
    output logic [9:0]  land_y,
    output logic [9:0]  scroll_dy,
    output logic        busy,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        is_plat
`ifdef PLATFORM_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);
    localparam logic [10:0] PW     = 11'(PLAT_W);
    localparam logic [10:0] PH     = 11'(PLAT_H);
    localparam logic [10:0] SL     = 11'(SCROLL_LINE);
    localparam logic [10:0] V_LIM  = 11'(V_MAX);
    localparam logic [9:0]  X_SPAN = 10'(H_MAX - PLAT_W);

    state_e           state_q;
    logic             frame_q;
    logic             frame_edge_q;
    logic [9:0]       bx_q, by_q, bs_q;
    logic             falling_q;
    logic [IDX_W-1:0] idx_q;
    logic             hit_q;
    logic [9:0]       win_y_q;
    logic [9:0]       plat_x_q [NUM_PLAT];
    logic [9:0]       plat_y_q [NUM_PLAT];
    logic             land_q;
    logic             busy_q;
    logic [9:0]       land_y_q;
    logic [9:0]       scroll_dy_q;

    logic [15:0]      lfsr_w;
    logic [5:0]       lfsr_unused;
    logic [10:0]      cur_x, cur_y, foot_y, ball_r, ball_x, ball_s;
    logic             cur_hit;
    logic [10:0]      new_y;
    logic             wrap;
    logic [9:0]       rand_x;
    logic [9:0]       dy_d;
    logic             is_plat_c;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .out   (lfsr_w)
    );
    assign lfsr_unused = lfsr_w[15:10];

    always_comb begin
        cur_x   = {1'b0, plat_x_q[idx_q]};
        cur_y   = {1'b0, plat_y_q[idx_q]};
        ball_x  = {1'b0, bx_q};
        ball_s  = {1'b0, bs_q};
        foot_y  = {1'b0, by_q} + ball_s;
        ball_r  = ball_x + ball_s;
        cur_hit = falling_q && (foot_y >= cur_y) && (foot_y <= cur_y + PH)
                  && (ball_r >= cur_x) && (ball_x <= cur_x + PW + ball_s);
        new_y   = cur_y + {1'b0, scroll_dy_q};
        wrap    = new_y > (V_LIM - 11'd1);
        // Folding by 512 keeps every respawn fully on screen
        rand_x  = (lfsr_w[9:0] < X_SPAN) ? lfsr_w[9:0] : lfsr_w[9:0] - 10'd512;
        dy_d    = 10'(SL - {1'b0, by_q});
    end

`ifdef PLATFORM_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum;
    assign score_sum = {1'b0, score_q} + {7'd0, scroll_dy_q};
    assign score     = score_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            frame_q      <= 1'b0;
            frame_edge_q <= 1'b0;
            bx_q         <= '0;
            by_q         <= '0;
            bs_q         <= '0;
            falling_q    <= 1'b0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            win_y_q      <= '0;
            land_q       <= 1'b0;
            busy_q       <= 1'b0;
            land_y_q     <= '0;
            scroll_dy_q  <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                plat_x_q[i] <= reset_x(i);
                plat_y_q[i] <= reset_y(i);
            end
`ifdef PLATFORM_SCORE_EN
            score_q      <= '0;
`endif
        end else begin
            frame_q      <= frame_clk;
            frame_edge_q <= frame_clk & ~frame_q;
            land_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_edge_q) begin
                        bx_q      <= BallX;
                        by_q      <= BallY;
                        bs_q      <= BallS;
                        falling_q <= ball_falling;
                        idx_q     <= '0;
                        hit_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (cur_hit && !hit_q) begin
                        hit_q   <= 1'b1;
                        win_y_q <= 10'(cur_y - ball_s);
                    end
                    if (idx_q == LAST_IDX) state_q <= LAND;
                    else                   idx_q   <= idx_q + 1'b1;
                end
                LAND: begin
                    if (hit_q) begin
                        land_q   <= 1'b1;
                        land_y_q <= win_y_q;
                    end
                    idx_q <= '0;
                    if ({1'b0, by_q} < SL) begin
                        scroll_dy_q <= dy_d;
                        state_q     <= SCROLL;
                    end else begin
                        scroll_dy_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                SCROLL: begin
                    if (wrap) begin
                        plat_y_q[idx_q] <= 10'(new_y - V_LIM);
                        plat_x_q[idx_q] <= rand_x;
                    end else begin
                        plat_y_q[idx_q] <= new_y[9:0];
                    end
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef PLATFORM_SCORE_EN
                        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        is_plat_c = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (({1'b0, DrawX} >= {1'b0, plat_x_q[i]})
                && ({1'b0, DrawX} < {1'b0, plat_x_q[i]} + PW)
                && ({1'b0, DrawY} >= {1'b0, plat_y_q[i]})
                && ({1'b0, DrawY} < {1'b0, plat_y_q[i]} + PH)
                && ({1'b0, DrawY} < V_LIM)) begin
                is_plat_c = 1'b1;
            end
        end
    end

    assign is_plat   = is_plat_c;
    assign land      = land_q;
    assign land_y    = land_y_q;
    assign scroll_dy = scroll_dy_q;
    assign busy      = busy_q;

endmodule
